// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1W1R bypass SRAM slice.
//   sram_state_t : controller state (INIT sweep, RUN)
//   lane_width() : bits per write-mask lane
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_t;

  // Bits per lane for a word of data_width split into num_wmasks lanes.
  function automatic int unsigned lane_width(input int unsigned data_width,
                                             input int unsigned num_wmasks);
    return data_width / num_wmasks;
  endfunction

  localparam int unsigned DEFAULT_LANE_W = lane_width(128, 4);

endpackage : sram_pkg

// File: rtl/sram_1w1r_array.sv
// Storage core: one lane-masked write port, one synchronous read port.
// No reset; contents are only ever written through port 0.
//   clk0   : clock
//   we0    : write enable
//   wmask0 : per-lane write enables, bit i -> lane i
//   addr0  : write address
//   din0   : write data
//   re1    : read enable; dout1 loads the addressed word on the edge
//   addr1  : read address
//   dout1  : read data (old contents on a same-edge write to addr1)
module sram_1w1r_array
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  clk0,
  input  logic                  we0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  localparam int unsigned LANE_W = lane_width(DATA_WIDTH, NUM_WMASKS);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Lane-masked write.
  always_ff @(posedge clk0) begin
    if (we0) begin
      for (int i = 0; i < int'(NUM_WMASKS); i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Synchronous read.
  always_ff @(posedge clk0) begin
    if (re1) begin
      dout1 <= mem[addr1];
    end
  end

endmodule : sram_1w1r_array

// File: rtl/sram_1w1r_bypass.sv
// 1W1R SRAM with zeroing init sweep, write-first same-address bypass and
// an optional extra read output register.
//   clk0        : clock for both ports
//   rstb0       : async active-low reset
//   csb0        : active-low write select
//   wmask0      : write lane enables
//   addr0/din0  : write address / data
//   csb1        : active-low read select
//   addr1       : read address
//   dout1       : read data, held between results
//   dout1_valid : one-cycle pulse per completed read
//   collision1  : with dout1_valid, read was merged with a same-edge write
//   ready       : init sweep done, ports accepted
module sram_1w1r_bypass
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision1,
  output logic                  ready
);

  localparam int unsigned LANE_W = lane_width(DATA_WIDTH, NUM_WMASKS);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

  sram_state_t      state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             ready_d;

  // Controller state register.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready      <= ready_d;
    end
  end

  // Next state: sweep one word per cycle, leave INIT after the last address.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = 1'b0;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_d == CNT_W'(DEPTH)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  logic                  run;
  logic                  arr_we;
  logic [NUM_WMASKS-1:0] arr_mask;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_din;
  logic [DATA_WIDTH-1:0] arr_dout;
  logic                  rd_fire;
  logic                  rd_hit;

  // Write port is owned by the sweep in INIT, by the user in RUN.
  always_comb begin
    run      = (state_q == RUN);
    arr_we   = run ? ~csb0 : 1'b1;
    arr_mask = run ? wmask0 : '1;
    arr_addr = run ? addr0 : init_cnt_q[ADDR_WIDTH-1:0];
    arr_din  = run ? din0 : '0;
    rd_fire  = run & ~csb1;
    rd_hit   = rd_fire & ~csb0 & (addr0 == addr1);
  end

  sram_1w1r_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WMASKS (NUM_WMASKS)
  ) u_array (
    .clk0   (clk0),
    .we0    (arr_we),
    .wmask0 (arr_mask),
    .addr0  (arr_addr),
    .din0   (arr_din),
    .re1    (rd_fire),
    .addr1  (addr1),
    .dout1  (arr_dout)
  );

  logic                  rd_v1;
  logic                  hit1;
  logic [NUM_WMASKS-1:0] mask1;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] merged;

  // Read stage 1: remember whether the same edge also wrote this word.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      rd_v1 <= 1'b0;
      hit1  <= 1'b0;
      mask1 <= '0;
      din1  <= '0;
    end else begin
      rd_v1 <= rd_fire;
      if (rd_fire) begin
        hit1  <= rd_hit;
        mask1 <= wmask0;
        din1  <= din0;
      end
    end
  end

  // Write-first merge: array returned pre-write data, overlay written lanes.
  always_comb begin
    merged = arr_dout;
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      if (hit1 && mask1[i]) begin
        merged[i*LANE_W +: LANE_W] = din1[i*LANE_W +: LANE_W];
      end
    end
  end

  if (OUT_REG == 0) begin : g_out_direct
    // Result registered straight into the outputs.
    always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
        collision1  <= 1'b0;
      end else begin
        dout1_valid <= rd_v1;
        collision1  <= rd_v1 & hit1;
        if (rd_v1) begin
          dout1 <= merged;
        end
      end
    end
  end else begin : g_out_reg
    logic                  v2;
    logic                  c2;
    logic [DATA_WIDTH-1:0] d2;

    // Extra pipeline stage ahead of the outputs.
    always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
        v2          <= 1'b0;
        c2          <= 1'b0;
        d2          <= '0;
        dout1       <= '0;
        dout1_valid <= 1'b0;
        collision1  <= 1'b0;
      end else begin
        v2 <= rd_v1;
        if (rd_v1) begin
          d2 <= merged;
          c2 <= hit1;
        end
        dout1_valid <= v2;
        collision1  <= v2 & c2;
        if (v2) begin
          dout1 <= d2;
        end
      end
    end
  end

endmodule : sram_1w1r_bypass

// File: tb/tb_sram_1w1r_bypass.sv
// Scoreboard bench for sram_1w1r_bypass: stimulus pushes expected read
// results from an array model; a negedge monitor pops and compares them.
module tb_sram_1w1r_bypass;

  localparam int DW      = 128;
  localparam int AW      = 5;
  localparam int NM      = 4;
  localparam int LW      = DW / NM;
  localparam int DEPTH   = 1 << AW;
  localparam int OUT_REG = 0;
  localparam int LAT     = OUT_REG + 1;

  logic          clk0   = 1'b0;
  logic          rstb0  = 1'b0;
  logic          csb0   = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] din0   = '0;
  logic          csb1   = 1'b1;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          collision1;
  logic          ready;

  sram_1w1r_bypass #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_WMASKS (NM),
    .OUT_REG    (OUT_REG)
  ) dut (
    .clk0        (clk0),
    .rstb0       (rstb0),
    .csb0        (csb0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .collision1  (collision1),
    .ready       (ready)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            issue;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  logic          tb_run = 1'b0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] seen_data = '0;
  logic          seen_coll = 1'b0;
  int            seen_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk0) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk0) begin : mon
    exp_t e;
    if (!rstb0) begin
      seen_data = '0;
    end else if (dout1_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", DW'(1), DW'(0));
      end else begin
        e = sb.pop_front();
        chk("dout1", dout1, e.data);
        chk("collision1", DW'(collision1), DW'(e.coll));
        chk("latency", DW'(cyc - e.issue), DW'(LAT));
      end
      seen_data = dout1;
      seen_coll = collision1;
      seen_cnt++;
    end else begin
      chk("hold", dout1, seen_data);
      chk("coll_idle", DW'(collision1), DW'(0));
    end
  end

  // One clock of port activity; the model is updated write-first.
  task automatic cycle_io(input logic we, input logic [NM-1:0] m, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    exp_t e;
    csb0 = ~we; wmask0 = m; addr0 = wa; din0 = wd;
    csb1 = ~re; addr1 = ra;
    if (tb_run) begin
      if (we) begin
        for (int i = 0; i < NM; i++) begin
          if (m[i]) model[wa][i*LW +: LW] = wd[i*LW +: LW];
        end
      end
      if (re) begin
        e.data  = model[ra];
        e.coll  = we && (wa == ra);
        e.issue = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk0); #1;
    csb0 = 1'b1; csb1 = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_io(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Assert reset, check reset outputs, release and time the init sweep
  // while hammering the ports with traffic that must be ignored.
  task automatic reset_and_init();
    int n;
    rstb0 = 1'b0;
    tb_run = 1'b0;
    sb.delete();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    #3;
    chk("rst_ready", DW'(ready), DW'(0));
    chk("rst_valid", DW'(dout1_valid), DW'(0));
    chk("rst_coll", DW'(collision1), DW'(0));
    chk("rst_dout", dout1, DW'(0));
    @(negedge clk0); #2;
    rstb0 = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      csb0 = 1'($urandom); csb1 = 1'($urandom);
      wmask0 = NM'($urandom); addr0 = AW'($urandom); addr1 = AW'($urandom);
      din0 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk0); #1;
      n++;
    end
    csb0 = 1'b1; csb1 = 1'b1;
    chk("ready_latency", DW'(n), DW'(32));
    tb_run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [DW-1:0] x;

    // Reset restarted in the middle of the sweep.
    rstb0 = 1'b0;
    #3;
    @(negedge clk0); #2;
    rstb0 = 1'b1;
    repeat (10) @(posedge clk0);
    #1;
    reset_and_init();

    // Every word reads back zero, back-to-back with no gaps.
    start = seen_cnt;
    for (int a = 0; a < DEPTH; a++) cycle_io(1'b0, '0, '0, '0, 1'b1, AW'(a));
    idle(LAT + 1);
    chk("burst_count", DW'(seen_cnt - start), DW'(32));

    // Full write then partial overwrite of lanes 0 and 2.
    cycle_io(1'b1, 4'b1111, 5'd3, {16{8'hA5}}, 1'b0, '0);
    cycle_io(1'b1, 4'b0101, 5'd3, {16{8'hFF}}, 1'b0, '0);
    cycle_io(1'b0, '0, '0, '0, 1'b1, 5'd3);
    idle(LAT + 1);
    chk("masked_write", seen_data, 128'hA5A5A5A5_FFFFFFFF_A5A5A5A5_FFFFFFFF);

    // Same-edge write/read of one address bypasses the written lane.
    cycle_io(1'b1, 4'b0010, 5'd7, {16{8'h11}}, 1'b1, 5'd7);
    idle(LAT + 1);
    chk("bypass_data", seen_data, 128'h00000000_00000000_11111111_00000000);
    chk("bypass_coll", DW'(seen_coll), DW'(1));

    // Read the cycle after a write: new data, no collision.
    x = {$urandom, $urandom, $urandom, $urandom};
    cycle_io(1'b1, 4'b1111, 5'd9, x, 1'b0, '0);
    cycle_io(1'b0, '0, '0, '0, 1'b1, 5'd9);
    idle(LAT + 1);
    chk("raw_next_data", seen_data, x);
    chk("raw_next_coll", DW'(seen_coll), DW'(0));

    // Same-edge accesses to different addresses do not interact.
    cycle_io(1'b1, 4'b1111, 5'd10, ~x, 1'b1, 5'd11);
    idle(LAT + 1);
    chk("diff_addr_data", seen_data, DW'(0));
    chk("diff_addr_coll", DW'(seen_coll), DW'(0));

    // Random traffic over a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      cycle_io(1'($urandom), NM'($urandom), AW'($urandom_range(0, 7)),
               {$urandom, $urandom, $urandom, $urandom},
               ($urandom % 4) != 0, AW'($urandom_range(0, 7)));
    end
    idle(LAT + 2);

    // Reset one cycle after a read is issued: the read must vanish.
    cycle_io(1'b0, '0, '0, '0, 1'b1, 5'd5);
    reset_and_init();

    // Contents were re-zeroed by the new sweep.
    for (int i = 0; i < 100; i++) begin
      cycle_io(1'($urandom), NM'($urandom), AW'($urandom),
               {$urandom, $urandom, $urandom, $urandom},
               1'($urandom), AW'($urandom));
    end
    idle(LAT + 2);
    chk("scoreboard_empty", DW'(sb.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_1w1r_bypass
